// File: rtl/fan_speed_ctrl.sv
`default_nettype none
// ============================================================================
// fan_speed_ctrl : fan on/off, 3-level speed FSM, registered PWM drive and an
//                  optional auto-off countdown timer (build with FAN_TIMER_EN).
// Revision       : 1.0
// ============================================================================
module fan_speed_ctrl #(
    parameter int unsigned TICKS_PER_SEC   = 1000,
    parameter int unsigned PWM_PERIOD      = 16,
    parameter int unsigned TIMER_STEP      = 30,
    parameter int unsigned TIMER_MAX_STEPS = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       press_power,
    input  logic       press_speed,
    input  logic       press_timer,
    output logic       fan_on,
    output logic [1:0] speed,
    output logic       pwm_out,
    output logic       timer_active,
    output logic [7:0] timer_left
);

    localparam int unsigned         C_PWM_CW   = $clog2(PWM_PERIOD);
    localparam int unsigned         C_DUTY_W   = $clog2(PWM_PERIOD + 1);
    localparam logic [C_PWM_CW-1:0] C_PWM_LAST = C_PWM_CW'(PWM_PERIOD - 1);
    localparam logic [C_DUTY_W-1:0] C_DUTY_LOW  = C_DUTY_W'(PWM_PERIOD / 4);
    localparam logic [C_DUTY_W-1:0] C_DUTY_MID  = C_DUTY_W'(PWM_PERIOD / 2);
    localparam logic [C_DUTY_W-1:0] C_DUTY_HIGH = C_DUTY_W'(PWM_PERIOD);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_LOW  = 2'd1,
        ST_MID  = 2'd2,
        ST_HIGH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                fan_on_q, fan_on_d;
    logic [C_PWM_CW-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [C_DUTY_W-1:0] duty_q, duty_d;
    logic                pwm_out_q, pwm_out_d;
    logic                timer_expire;

    // ------------------------------------------------------------------------
    // Operating state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (press_power) begin
            state_d = (state_q == ST_OFF) ? ST_LOW : ST_OFF;
        end else if (state_q != ST_OFF) begin
            if (timer_expire) begin
                state_d = ST_OFF;
            end else if (press_speed) begin
                case (state_q)
                    ST_LOW:  state_d = ST_MID;
                    ST_MID:  state_d = ST_HIGH;
                    ST_HIGH: state_d = ST_LOW;
                    default: state_d = ST_OFF;
                endcase
            end
        end
        fan_on_d = (state_d != ST_OFF);
    end

    // ------------------------------------------------------------------------
    // PWM: duty only changes on a period boundary, except power-off which
    // zeroes it at once so no stray partial pulse follows.
    // ------------------------------------------------------------------------
    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == C_PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
        duty_d    = duty_q;
        if (state_d == ST_OFF) begin
            duty_d = '0;
        end else if (pwm_cnt_q == C_PWM_LAST) begin
            case (state_d)
                ST_LOW:  duty_d = C_DUTY_LOW;
                ST_MID:  duty_d = C_DUTY_MID;
                ST_HIGH: duty_d = C_DUTY_HIGH;
                default: duty_d = '0;
            endcase
        end
        pwm_out_d = (C_DUTY_W'(pwm_cnt_q) < duty_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_OFF;
            fan_on_q  <= 1'b0;
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            pwm_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fan_on_q  <= fan_on_d;
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            pwm_out_q <= pwm_out_d;
        end
    end

`ifdef FAN_TIMER_EN
    // ------------------------------------------------------------------------
    // Auto-off countdown
    // ------------------------------------------------------------------------
    localparam int unsigned          C_PRESC_W    = $clog2(TICKS_PER_SEC);
    localparam logic [C_PRESC_W-1:0] C_PRESC_LAST = C_PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [7:0]           C_TIMER_MAX  = 8'(TIMER_STEP * TIMER_MAX_STEPS);
    localparam logic [8:0]           C_STEP9      = 9'(TIMER_STEP);

    logic [C_PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]           timer_left_q, timer_left_d;
    logic                 timer_active_q, timer_active_d;
    logic [8:0]           timer_sum;
    logic                 sec_wrap;
    logic                 timer_press;

    assign sec_wrap     = timer_active_q && (presc_q == C_PRESC_LAST);
    assign timer_press  = press_timer && !press_power && (state_q != ST_OFF);
    // A press in the same cycle overrides the decrement, including the last one.
    assign timer_expire = sec_wrap && (timer_left_q == 8'd1) && !timer_press;
    assign timer_sum    = {1'b0, timer_left_q} + C_STEP9;

    always_comb begin
        timer_left_d = timer_left_q;
        presc_d      = presc_q;
        if (timer_active_q) begin
            presc_d = sec_wrap ? '0 : presc_q + 1'b1;
        end
        if (timer_press) begin
            if (timer_left_q == C_TIMER_MAX) begin
                timer_left_d = '0;
                presc_d      = '0;
            end else begin
                // Adding onto a partly elapsed value saturates at the maximum.
                timer_left_d = (timer_sum > {1'b0, C_TIMER_MAX}) ? C_TIMER_MAX
                                                                 : timer_sum[7:0];
                if (!timer_active_q) begin
                    presc_d = '0;
                end
            end
        end else if (sec_wrap) begin
            timer_left_d = timer_left_q - 8'd1;
        end
        if (state_d == ST_OFF) begin
            timer_left_d = '0;
            presc_d      = '0;
        end
        timer_active_d = (timer_left_d != 8'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q        <= '0;
            timer_left_q   <= '0;
            timer_active_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            timer_left_q   <= timer_left_d;
            timer_active_q <= timer_active_d;
        end
    end

    assign timer_left   = timer_left_q;
    assign timer_active = timer_active_q;
`else
    logic unused_timer;
    assign unused_timer = ^{press_timer, 1'(TICKS_PER_SEC), 1'(TIMER_STEP),
                            1'(TIMER_MAX_STEPS)};
    assign timer_expire = 1'b0;
    assign timer_left   = 8'd0;
    assign timer_active = 1'b0;
`endif

    assign fan_on  = fan_on_q;
    assign speed   = state_q;
    assign pwm_out = pwm_out_q;

endmodule
`default_nettype wire

// File: tb/tb_fan_speed_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fan_speed_ctrl : directed + random stimulus against a behavioural model.
// Revision          : 1.0
// ============================================================================
module tb_fan_speed_ctrl;

    localparam int TPS  = 5;
    localparam int P    = 16;
    localparam int STEP = 2;
    localparam int MAXS = 4;
    localparam int TMAX = STEP * MAXS;
`ifdef FAN_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic       clk         = 1'b0;
    logic       reset_n     = 1'b0;
    logic       press_power = 1'b0;
    logic       press_speed = 1'b0;
    logic       press_timer = 1'b0;
    logic       fan_on;
    logic [1:0] speed;
    logic       pwm_out;
    logic       timer_active;
    logic [7:0] timer_left;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state, in spec terms
    bit m_on;
    int m_spd;
    int m_tl;
    int m_sec;
    int m_duty;
    int m_cyc;
    bit m_pwm;

    fan_speed_ctrl #(
        .TICKS_PER_SEC  (TPS),
        .PWM_PERIOD     (P),
        .TIMER_STEP     (STEP),
        .TIMER_MAX_STEPS(MAXS)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .press_power (press_power),
        .press_speed (press_speed),
        .press_timer (press_timer),
        .fan_on      (fan_on),
        .speed       (speed),
        .pwm_out     (pwm_out),
        .timer_active(timer_active),
        .timer_left  (timer_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int duty_of(input int spd);
        case (spd)
            1:       return P / 4;
            2:       return P / 2;
            3:       return P;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_on = 0; m_spd = 0; m_tl = 0; m_sec = 0; m_duty = 0; m_cyc = 0; m_pwm = 0;
    endtask

    // One clock edge of the reference behaviour with the given button pulses.
    task automatic model_edge(input bit p, input bit s, input bit t);
        int phase;
        bit wrap;
        bit tp;
        phase = m_cyc % P;
        m_pwm = (phase < m_duty);
        wrap  = (m_tl != 0) && (m_sec == TPS - 1);
        if (m_tl != 0) m_sec = (m_sec + 1) % TPS;
        tp = TIMER_EN && t && !p && m_on;
        if (p) begin
            m_on = !m_on;
            if (m_on) m_spd = 1;
        end else if (m_on) begin
            if (tp) begin
                if (m_tl == TMAX) begin
                    m_tl = 0; m_sec = 0;
                end else begin
                    if (m_tl == 0) m_sec = 0;
                    m_tl = (m_tl + STEP > TMAX) ? TMAX : m_tl + STEP;
                end
            end else if (wrap) begin
                m_tl = m_tl - 1;
                if (m_tl == 0) m_on = 0;
            end
            if (m_on && s) m_spd = (m_spd == 3) ? 1 : m_spd + 1;
        end
        if (!m_on) begin
            m_spd = 0; m_tl = 0; m_sec = 0; m_duty = 0;
        end else if (phase == P - 1) begin
            m_duty = duty_of(m_spd);
        end
        m_cyc++;
    endtask

    task automatic check_all();
        chk("fan_on",       fan_on,       m_on);
        chk("speed",        speed,        m_spd);
        chk("pwm_out",      pwm_out,      m_pwm);
        chk("timer_left",   timer_left,   m_tl);
        chk("timer_active", timer_active, m_tl != 0);
    endtask

    task automatic cycle(input bit p, input bit s, input bit t);
        press_power = p;
        press_speed = s;
        press_timer = t;
        @(posedge clk);
        model_edge(p, s, t);
        #1;
        press_power = 1'b0;
        press_speed = 1'b0;
        press_timer = 1'b0;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Count pwm_out highs over one full PWM period.
    task automatic pwm_window(output int hi);
        hi = 0;
        for (int i = 0; i < P; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            hi += int'(pwm_out);
        end
    endtask

    initial begin
        int hi;
        bit rp, rs, rt;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset_n = 1'b1;

        // Power on, LOW duty
        cycle(1'b1, 1'b0, 1'b0);
        chk("on_fan",   fan_on, 1);
        chk("on_speed", speed,  1);
        idle(2 * P);
        pwm_window(hi);
        chk("low_duty", hi, P / 4);

        // Speed cycling
        cycle(1'b0, 1'b1, 1'b0);
        chk("spd_mid", speed, 2);
        idle(2 * P);
        pwm_window(hi);
        chk("mid_duty", hi, P / 2);
        cycle(1'b0, 1'b1, 1'b0);
        chk("spd_high", speed, 3);
        idle(2 * P);
        pwm_window(hi);
        chk("high_duty", hi, P);
        cycle(1'b0, 1'b1, 1'b0);
        chk("spd_wrap", speed, 1);

        // Power off, speed ignored in OFF
        cycle(1'b1, 1'b0, 1'b0);
        chk("off_fan", fan_on, 0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("off_speed_ign", speed, 0);
        pwm_window(hi);
        chk("off_duty", hi, 0);

`ifdef FAN_TIMER_EN
        // Single step expiry: exactly STEP*TPS cycles after the load
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        chk("tmr_load", timer_left, STEP);
        idle(STEP * TPS - 1);
        chk("tmr_before_exp", fan_on, 1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("tmr_expired", fan_on, 0);
        chk("tmr_exp_left", timer_left, 0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("tmr_exp_pwm", pwm_out, 0);

        // Accumulate to max then cancel
        cycle(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= MAXS + 1; k++) begin
            cycle(1'b0, 1'b0, 1'b1);
            chk("tmr_accum", timer_left, (k <= MAXS) ? k * STEP : 0);
        end
        chk("tmr_cancel_act", timer_active, 0);

        // Power + speed together while LOW with timer running
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        chk("pw_sp_fan", fan_on, 0);
        chk("pw_sp_tmr", timer_left, 0);
`else
        // Timer presses have no effect in this build
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        chk("notmr_left", timer_left, 0);
        chk("notmr_act",  timer_active, 0);
        chk("notmr_spd",  speed, 1);
        cycle(1'b1, 1'b1, 1'b0);
        chk("pw_sp_fan", fan_on, 0);
`endif

        // Asynchronous reset in the middle of a running period
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        idle(3);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_fan",   fan_on,       0);
        chk("arst_speed", speed,        0);
        chk("arst_pwm",   pwm_out,      0);
        chk("arst_left",  timer_left,   0);
        chk("arst_act",   timer_active, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rp = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 7) == 0);
            rt = ($urandom_range(0, 5) == 0);
            cycle(rp, rs, rt);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
